// File: rtl/neurex_pkg.sv
// Shared types and helpers for the top_neurex operand stream generator.
package neurex_pkg;

  typedef enum logic [1:0] {
    RAMP  = 2'd0,
    CONST = 2'd1,
    IDENT = 2'd2,
    RSVD  = 2'd3
  } stream_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } gen_state_e;

  localparam int unsigned CeilWidth = 64;

  // ceil(val / 2**shift): shift down, round up if any discarded bit is set.
  function automatic logic [CeilWidth-1:0] ceil_div_pow2(input logic [CeilWidth-1:0] val,
                                                         input int unsigned       shift);
    logic [CeilWidth-1:0] mask;
    mask = (CeilWidth'(1) << shift) - CeilWidth'(1);
    return (val >> shift) + ((|(val & mask)) ? CeilWidth'(1) : CeilWidth'(0));
  endfunction

endpackage

// File: rtl/operand_stream_gen_pattern.sv
// Combinational lane-data generator: maps (mode, beat, lane) to a data value for one lane group.
module operand_pattern
  import neurex_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned SYS_COL    = 4,
  parameter bit          IS_WEIGHT  = 1'b0
) (
  input  stream_mode_e          mode,
  input  logic [CNT_WIDTH-1:0]  beat,
  output logic [DATA_WIDTH-1:0] lane_data [LANES]
);

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_data[j] = '0;
      if (IS_WEIGHT) begin
        case (mode)
          CONST:   lane_data[j] = DATA_WIDTH'(1);
          IDENT:   lane_data[j] = ((beat & CNT_WIDTH'(SYS_COL - 1)) == CNT_WIDTH'(j)) ?
                                  DATA_WIDTH'(1) : DATA_WIDTH'(0);
          // Ramp wraps silently at the data width.
          default: lane_data[j] = DATA_WIDTH'(beat) + DATA_WIDTH'(j);
        endcase
      end else begin
        if (mode == CONST || !beat[0]) begin
          lane_data[j] = DATA_WIDTH'(j + 1);
        end else begin
          lane_data[j] = DATA_WIDTH'(j + 5);
        end
      end
    end
  end

endmodule

// File: rtl/operand_stream_gen.sv
// Operand stream generator for top_neurex: latches GEMM dims on start and emits registered
// input/weight beats with backpressure, done pulse and synchronous abort.
module operand_stream_gen
  import neurex_pkg::*;
#(
  parameter int unsigned SYS_ROW    = 4,
  parameter int unsigned SYS_COL    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_common,
  input  logic [DATA_WIDTH-1:0] num_out,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  in_en,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] in_data [SYS_ROW],
  output logic [DATA_WIDTH-1:0] w_data  [SYS_COL],
  output logic [CNT_WIDTH-1:0]  beat_idx
);

  localparam int unsigned RowShift = $clog2(SYS_ROW);
  localparam int unsigned ColShift = $clog2(SYS_COL);

  gen_state_e           state_q;
  stream_mode_e         mode_q;
  logic [CNT_WIDTH-1:0] i_q, w_q, l_q, beat_idx_q;
  logic                 busy_q, done_q, in_en_q, w_en_q;
  logic [DATA_WIDTH-1:0] in_data_q [SYS_ROW];
  logic [DATA_WIDTH-1:0] w_data_q  [SYS_COL];

  logic [CNT_WIDTH-1:0] prod_in, prod_w, i_calc, w_calc, l_calc;
  logic [CNT_WIDTH-1:0] i_sel, w_sel, nxt_idx;
  logic                 idle_start, nxt_in_en, nxt_w_en, last_beat;
  stream_mode_e         mode_sel;
  logic [DATA_WIDTH-1:0] in_pat [SYS_ROW];
  logic [DATA_WIDTH-1:0] w_pat  [SYS_COL];
  logic [DATA_WIDTH-1:0] in_nxt [SYS_ROW];
  logic [DATA_WIDTH-1:0] w_nxt  [SYS_COL];

  always_comb begin
    prod_in = CNT_WIDTH'(num_in) * CNT_WIDTH'(num_common);
    prod_w  = CNT_WIDTH'(num_common) * CNT_WIDTH'(num_out);
    i_calc  = CNT_WIDTH'(ceil_div_pow2(CeilWidth'(prod_in), RowShift));
    w_calc  = CNT_WIDTH'(ceil_div_pow2(CeilWidth'(prod_w), ColShift));
    l_calc  = (i_calc > w_calc) ? i_calc : w_calc;
  end

  // The next beat is beat 0 of a fresh run when starting, otherwise the successor of the
  // beat on the outputs; it is precomputed so every output can be registered.
  always_comb begin
    idle_start = (state_q == IDLE) && start;
    mode_sel   = idle_start ? stream_mode_e'(mode) : mode_q;
    i_sel      = idle_start ? i_calc : i_q;
    w_sel      = idle_start ? w_calc : w_q;
    nxt_idx    = idle_start ? '0 : beat_idx_q + CNT_WIDTH'(1);
    nxt_in_en  = nxt_idx < i_sel;
    nxt_w_en   = nxt_idx < w_sel;
    last_beat  = beat_idx_q == (l_q - CNT_WIDTH'(1));
    for (int j = 0; j < SYS_ROW; j++) in_nxt[j] = nxt_in_en ? in_pat[j] : '0;
    for (int j = 0; j < SYS_COL; j++) w_nxt[j]  = nxt_w_en  ? w_pat[j]  : '0;
  end

  operand_pattern #(
    .LANES      (SYS_ROW),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .SYS_COL    (SYS_COL),
    .IS_WEIGHT  (1'b0)
  ) u_in_pattern (
    .mode      (mode_sel),
    .beat      (nxt_idx),
    .lane_data (in_pat)
  );

  operand_pattern #(
    .LANES      (SYS_COL),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .SYS_COL    (SYS_COL),
    .IS_WEIGHT  (1'b1)
  ) u_w_pattern (
    .mode      (mode_sel),
    .beat      (nxt_idx),
    .lane_data (w_pat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      mode_q     <= RAMP;
      i_q        <= '0;
      w_q        <= '0;
      l_q        <= '0;
      beat_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_en_q    <= 1'b0;
      w_en_q     <= 1'b0;
      for (int j = 0; j < SYS_ROW; j++) in_data_q[j] <= '0;
      for (int j = 0; j < SYS_COL; j++) w_data_q[j]  <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      beat_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_en_q    <= 1'b0;
      w_en_q     <= 1'b0;
      for (int j = 0; j < SYS_ROW; j++) in_data_q[j] <= '0;
      for (int j = 0; j < SYS_COL; j++) w_data_q[j]  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q <= stream_mode_e'(mode);
            i_q    <= i_calc;
            w_q    <= w_calc;
            l_q    <= l_calc;
            if (l_calc != '0) begin
              state_q    <= STREAM;
              busy_q     <= 1'b1;
              beat_idx_q <= nxt_idx;
              in_en_q    <= nxt_in_en;
              w_en_q     <= nxt_w_en;
              in_data_q  <= in_nxt;
              w_data_q   <= w_nxt;
            end else begin
              state_q <= FIN;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (last_beat) begin
              state_q    <= FIN;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              beat_idx_q <= '0;
              in_en_q    <= 1'b0;
              w_en_q     <= 1'b0;
              for (int j = 0; j < SYS_ROW; j++) in_data_q[j] <= '0;
              for (int j = 0; j < SYS_COL; j++) w_data_q[j]  <= '0;
            end else begin
              beat_idx_q <= nxt_idx;
              in_en_q    <= nxt_in_en;
              w_en_q     <= nxt_w_en;
              in_data_q  <= in_nxt;
              w_data_q   <= w_nxt;
            end
          end
        end
        FIN: begin
          // An empty run enters FIN without done, so it spends one extra cycle here.
          if (done_q) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_en    = in_en_q;
  assign w_en     = w_en_q;
  assign in_data  = in_data_q;
  assign w_data   = w_data_q;
  assign beat_idx = beat_idx_q;

endmodule
